// File: rtl/interrupt_priority_engine.sv
// Registered rotating-priority resolver owning the in-service register and lowest-priority pointer.
// Optional auto-EOI acknowledge behaviour is enabled by defining IPE_AUTO_EOI_EN.
module interrupt_priority_engine #(
  parameter int NUM_IRQ = 8,
  localparam int PTR_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
`ifdef IPE_AUTO_EOI_EN
  input  logic               aeoi_mode,
`endif
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               special_mask_mode,
  input  logic               special_fully_nested,
  input  logic               ack,
  input  logic               eoi_nonspecific,
  input  logic               eoi_specific,
  input  logic [PTR_W-1:0]   eoi_level,
  input  logic               eoi_rotate,
  input  logic               set_priority,
  input  logic [PTR_W-1:0]   priority_level,
  output logic               int_req,
  output logic [PTR_W-1:0]   int_id,
  output logic               ack_spurious,
  output logic [NUM_IRQ-1:0] isr,
  output logic [PTR_W-1:0]   lowest_priority
);

  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [PTR_W-1:0]   lp_q, lp_d;
  logic               int_req_q, int_req_d;
  logic [PTR_W-1:0]   int_id_q, int_id_d;
  logic               spur_q, spur_d;

  logic [NUM_IRQ-1:0] pending, blk;
  logic               blk_any, win_any, hi_isr_any;
  int                 blk_pos;
  logic [PTR_W-1:0]   win_lvl, hi_isr_lvl, lvl;
  logic               aeoi, ack_ok, spec_ok, prio_ok, eoi_hit;
  logic [PTR_W-1:0]   eoi_lvl;

  // Rank position 0 is the level just above LP; position NUM_IRQ-1 is LP itself.
  function automatic logic [PTR_W-1:0] lvl_at(input logic [PTR_W-1:0] lp, input int pos);
    int v;
    v = int'(lp) + 1 + pos;
    if (v >= NUM_IRQ) v = v - NUM_IRQ;
    return PTR_W'(v);
  endfunction

`ifdef IPE_AUTO_EOI_EN
  assign aeoi = aeoi_mode;
`else
  assign aeoi = 1'b0;
`endif

  always_comb begin
    pending    = irr & ~imr;
    blk        = special_mask_mode ? (isr_q & ~imr) : isr_q;
    blk_any    = 1'b0;
    blk_pos    = 0;
    win_any    = 1'b0;
    win_lvl    = '0;
    hi_isr_any = 1'b0;
    hi_isr_lvl = '0;
    lvl        = '0;
    // Walk from lowest to highest rank so the last hit is the best one.
    for (int p = NUM_IRQ - 1; p >= 0; p--) begin
      lvl = lvl_at(lp_q, p);
      if (blk[lvl]) begin
        blk_any = 1'b1;
        blk_pos = p;
      end
      if (isr_q[lvl]) begin
        hi_isr_any = 1'b1;
        hi_isr_lvl = lvl;
      end
    end
    for (int p = NUM_IRQ - 1; p >= 0; p--) begin
      lvl = lvl_at(lp_q, p);
      if (pending[lvl] && (!blk_any || (p < blk_pos) ||
                           (special_fully_nested && (p == blk_pos)))) begin
        win_any = 1'b1;
        win_lvl = lvl;
      end
    end
  end

  always_comb begin
    isr_d   = isr_q;
    lp_d    = lp_q;
    ack_ok  = ack && int_req_q;
    spec_ok = (32'(eoi_level) < 32'(NUM_IRQ));
    prio_ok = (32'(priority_level) < 32'(NUM_IRQ));
    eoi_hit = 1'b0;
    eoi_lvl = '0;
    // A specific EOI suppresses a simultaneous non-specific one, even when out of range.
    if (eoi_specific) begin
      if (spec_ok && isr_q[eoi_level]) begin
        eoi_hit = 1'b1;
        eoi_lvl = eoi_level;
      end
    end else if (eoi_nonspecific && hi_isr_any) begin
      eoi_hit = 1'b1;
      eoi_lvl = hi_isr_lvl;
    end
    if (eoi_hit) begin
      isr_d[eoi_lvl] = 1'b0;
      if (eoi_rotate) lp_d = eoi_lvl;
    end
    // Acknowledge is applied after the EOI clear so a set on the same bit wins.
    if (ack_ok) begin
      if (!aeoi) isr_d[int_id_q] = 1'b1;
      else if (eoi_rotate) lp_d = int_id_q;
    end
    if (set_priority && prio_ok) lp_d = priority_level;
    int_req_d = ack_ok ? 1'b0 : win_any;
    int_id_d  = int_req_d ? win_lvl : int_id_q;
    spur_d    = ack && !int_req_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      isr_q     <= '0;
      lp_q      <= PTR_W'(NUM_IRQ - 1);
      int_req_q <= 1'b0;
      int_id_q  <= '0;
      spur_q    <= 1'b0;
    end else begin
      isr_q     <= isr_d;
      lp_q      <= lp_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
      spur_q    <= spur_d;
    end
  end

  assign int_req         = int_req_q;
  assign int_id          = int_id_q;
  assign ack_spurious    = spur_q;
  assign isr             = isr_q;
  assign lowest_priority = lp_q;

endmodule

// File: tb/tb_interrupt_priority_engine.sv
// Directed bench for interrupt_priority_engine, NUM_IRQ=8, default build.
module tb_interrupt_priority_engine;
  localparam int N = 8;
  localparam int PW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  irr, imr;
  logic          special_mask_mode, special_fully_nested;
  logic          ack, eoi_nonspecific, eoi_specific, eoi_rotate, set_priority;
  logic [PW-1:0] eoi_level, priority_level;
  logic          int_req, ack_spurious;
  logic [PW-1:0] int_id, lowest_priority;
  logic [N-1:0]  isr;

  int checks = 0;
  int errors = 0;

  interrupt_priority_engine #(.NUM_IRQ(N)) dut (
    .clock(clock), .reset(reset), .irr(irr), .imr(imr),
    .special_mask_mode(special_mask_mode), .special_fully_nested(special_fully_nested),
    .ack(ack), .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .eoi_rotate(eoi_rotate), .set_priority(set_priority),
    .priority_level(priority_level), .int_req(int_req), .int_id(int_id),
    .ack_spurious(ack_spurious), .isr(isr), .lowest_priority(lowest_priority)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    ack = 0; eoi_nonspecific = 0; eoi_specific = 0; eoi_rotate = 0; set_priority = 0;
  endtask

  initial begin
    reset = 1; irr = '0; imr = '0; special_mask_mode = 0; special_fully_nested = 0;
    eoi_level = '0; priority_level = '0;
    clear_pulses();
    @(negedge clock);
    step(); step();
    reset = 0;
    chk("rst_int_req", int_req, 0);
    chk("rst_int_id", int_id, 0);
    chk("rst_isr", isr, 0);
    chk("rst_lp", lowest_priority, 7);
    chk("rst_spur", ack_spurious, 0);

    irr = 8'h28; step();
    chk("req_28", int_req, 1);
    chk("id_28", int_id, 3);

    ack = 1; step(); ack = 0;
    chk("ack_isr", isr, 8'h08);
    chk("ack_forced_low", int_req, 0);
    chk("ack_id_hold", int_id, 3);
    step();
    chk("same_level_blocked", int_req, 0);

    irr = 8'h20; step();
    chk("lower_blocked", int_req, 0);

    special_fully_nested = 1; irr = 8'h08; step();
    chk("sfn_req", int_req, 1);
    chk("sfn_id", int_id, 3);

    special_fully_nested = 0; irr = 8'h00; step();
    irr = 8'h02; step();
    chk("nest_req", int_req, 1);
    chk("nest_id", int_id, 1);
    ack = 1; step(); ack = 0; irr = 8'h00;
    chk("isr_0a", isr, 8'h0A);

    eoi_nonspecific = 1; eoi_rotate = 1; step(); clear_pulses();
    chk("nseoi_isr", isr, 8'h08);
    chk("nseoi_rot_lp", lowest_priority, 1);

    irr = 8'h06; step();
    chk("rot_req", int_req, 1);
    chk("rot_id", int_id, 2);

    irr = 8'h00; set_priority = 1; priority_level = 7; step(); clear_pulses();
    chk("setpri_lp", lowest_priority, 7);

    eoi_specific = 1; eoi_level = 3; step(); clear_pulses();
    chk("seoi_isr", isr, 8'h00);
    chk("seoi_lp", lowest_priority, 7);

    chk("pre_spur_req", int_req, 0);
    ack = 1; step(); ack = 0;
    chk("spur_pulse", ack_spurious, 1);
    chk("spur_isr", isr, 8'h00);
    step();
    chk("spur_one_cycle", ack_spurious, 0);

    irr = 8'h10; step();
    chk("id_4", int_id, 4);
    ack = 1; eoi_specific = 1; eoi_level = 4; step(); clear_pulses(); irr = 8'h00;
    chk("ack_eoi_set_wins", isr, 8'h10);

    eoi_nonspecific = 1; eoi_rotate = 1; set_priority = 1; priority_level = 5;
    step(); clear_pulses();
    chk("setpri_vs_rot_isr", isr, 8'h00);
    chk("setpri_vs_rot_lp", lowest_priority, 5);

    irr = 8'h41; step();
    chk("wrap_id", int_id, 6);
    imr = 8'h40; step();
    chk("mask_id", int_id, 0);
    imr = 8'h00; step();
    chk("unmask_id", int_id, 6);
    ack = 1; step(); ack = 0;
    chk("isr_40", isr, 8'h40);

    irr = 8'h02; step();
    chk("smm_off_blocked", int_req, 0);
    special_mask_mode = 1; imr = 8'h40; step();
    chk("smm_req", int_req, 1);
    chk("smm_id", int_id, 1);

    reset = 1; set_priority = 1; priority_level = 2; ack = 1; step();
    reset = 0; clear_pulses(); irr = 8'h00; imr = 8'h00; special_mask_mode = 0;
    chk("midrst_isr", isr, 8'h00);
    chk("midrst_lp", lowest_priority, 7);
    chk("midrst_req", int_req, 0);
    chk("midrst_id", int_id, 0);
    step();
    chk("post_rst_lp", lowest_priority, 7);
    chk("post_rst_spur", ack_spurious, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
